rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (wr/addr3/data3) between the in-order pipeline writeback stage and a multi-cycle unit (mult/div result-to-GPR path) that completes out of band.
- Pipeline WB has priority. Multi-cycle results wait in a one-entry hold register.
- A busy scoreboard marks GPRs with outstanding multi-cycle writes so decode can stall on them.
- Sits between the WB stage, the multi-cycle unit and the register file.

Parameters:
- STARVE_LIMIT, 4, cycles a held result may lose arbitration before stall_req is raised (1..15).
- DATA_W, 32, write data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; clears all state.
- wb_wr  in  1  pipeline writeback request (no backpressure).
- wb_addr  in  5  pipeline destination register.
- wb_data  in  DATA_W  pipeline writeback data.
- mc_valid  in  1  multi-cycle result offered.
- mc_ready  out  1  hold register free; the result is accepted when mc_valid&mc_ready at posedge.
- mc_addr  in  5  multi-cycle destination register.
- mc_data  in  DATA_W  multi-cycle result.
- sb_set  in  1  decode issued a multi-cycle op; mark sb_addr busy.
- sb_addr  in  5  register to mark busy.
- rs_addr  in  5  decode source query 1.
- rt_addr  in  5  decode source query 2.
- rs_busy  out  1  busy[rs_addr], combinational.
- rt_busy  out  1  busy[rt_addr], combinational.
- stall_req  out  1  request that the pipeline inject a WB bubble.
- rf_wr  out  1  to register file wr.
- rf_addr  out  5  to register file addr3.
- rf_data  out  DATA_W  to register file data3.

Behaviour:
- Reset values (async, reset=0):
  - State IDLE; hold register invalid.
  - Starve counter 0; busy vector all 0.
  - Outputs: mc_ready=1, stall_req=0.
- Write-port outputs are combinational and valid for the whole cycle, because the register file samples on negedge clk.
- pipe_live = wb_wr & (wb_addr!=0).
- Port mux:
  - If pipe_live: rf_wr=1, rf_addr=wb_addr, rf_data=wb_data.
  - Else if held valid: rf_wr=1, rf_addr/rf_data = held values. This is a grant.
  - Else rf_wr=0, rf_addr=0, rf_data=0.
- mc_ready = ~held_valid. There is no same-cycle pass-through, so minimum accept-to-write latency is 1 cycle.
- An accepted result with mc_addr==0 is discarded: no hold, no write, scoreboard unchanged.
- States:
  - IDLE: hold empty. Accept with mc_addr!=0 -> HELD, counter=0.
  - HELD: on grant -> IDLE at next posedge (mc_ready=1 the cycle after grant). On no grant, counter+1; when counter reaches STARVE_LIMIT -> FORCE.
  - FORCE: stall_req=1. The pipeline must present wb_wr=0 the following cycle. On grant -> IDLE, and stall_req drops at that posedge.
- A new accept is impossible in HELD/FORCE because mc_ready=0.
- Scoreboard: busy[31:1]; busy[0] is hard 0.
  - sb_set sets busy[sb_addr] at posedge (ignored for sb_addr 0).
  - A grant clears busy[held_addr].
  - Set and clear of the same register in the same cycle: set wins.
- pipe_live to a busy register is a WAW protocol violation. The write proceeds and the busy bit is unchanged; decode is responsible for preventing it via rs/rt_busy.
- Reset mid-operation drops the held result with no write, and clears busy bits and stall_req immediately.

Optional Feature:
- Macro RF_WB_STARVE_EN.
- Defined: the starve counter and the FORCE state exist as described.
- Undefined: there is no counter or FORCE state. stall_req is tied 0, and a held result waits in HELD until a free write slot occurs.

Decomposition:
- Shared package/header:
  - REG_ADDR_W=5.
  - REG_ZERO=5'd0.
  - The state encoding IDLE=2'd0, HELD=2'd1, FORCE=2'd2.
- One natural sub-module: rf_scoreboard (busy vector, set/clear, two query ports). The arbiter FSM and port mux remain in rf_wb_arbiter.

Test Plan:
- Async reset while in HELD with busy[8]=1 -> rf_wr=0, mc_ready=1, rs_busy for addr 8 = 0, with no posedge required.
- wb_wr=0, then accept mc_addr=8, mc_data=0xDEADBEEF -> next cycle rf_wr=1, rf_addr=8, rf_data=0xDEADBEEF; busy[8] clears; mc_ready=1 one cycle later.
- Held result for r9 while wb_wr=1, wb_addr=3 for 4 cycles (STARVE_LIMIT=4):
  - Each of those cycles shows rf_addr=3.
  - stall_req=1 after 4 losses.
  - Bench then drives wb_wr=0 -> r9 written and stall_req=0 next cycle.
  - With RF_WB_STARVE_EN undefined, stall_req stays 0 throughout.
- Held r9 while wb_wr=1, wb_addr=0 -> this counts as a free slot, so r9 is written that cycle.
- sb_set for r12 in the same cycle as a grant for r12 -> busy[12]=1 afterwards. Separately, accepting mc_addr=0 leaves mc_ready=1 and produces no rf_wr.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter and its busy scoreboard.
package rf_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        FORCE = 2'd2
    } arb_state_e;

    // r0 is hardwired to zero, so a write or busy mark aimed at it is meaningless.
    function automatic logic is_gpr(input logic [REG_ADDR_W-1:0] addr);
        return addr != REG_ZERO;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy bits for GPRs with an outstanding multi-cycle write; r0 is never busy.
module rf_scoreboard
    import rf_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_i,
    input  logic [REG_ADDR_W-1:0] set_addr_i,
    input  logic                  clr_i,
    input  logic [REG_ADDR_W-1:0] clr_addr_i,
    input  logic [REG_ADDR_W-1:0] rs_addr_i,
    input  logic [REG_ADDR_W-1:0] rt_addr_i,
    output logic                  rs_busy_o,
    output logic                  rt_busy_o
);

    logic [NUM_REGS-1:1] busy_q;
    logic [NUM_REGS-1:0] busy_full;
    logic [NUM_REGS-1:0] busy_d;

    assign busy_full = {busy_q, 1'b0};

    // Clear is applied first so a same-cycle set on the same register wins.
    always_comb begin
        busy_d = busy_full;
        if (clr_i && is_gpr(clr_addr_i)) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_i && is_gpr(set_addr_i)) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d[NUM_REGS-1:1];
        end
    end

    assign rs_busy_o = busy_full[rs_addr_i];
    assign rt_busy_o = busy_full[rt_addr_i];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between pipeline WB (priority) and a held multi-cycle result.
// Optional starvation escape (counter + FORCE state driving stall_req) is enabled by RF_WB_STARVE_EN.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_wr,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  mc_valid,
    output logic                  mc_ready,
    input  logic [REG_ADDR_W-1:0] mc_addr,
    input  logic [DATA_W-1:0]     mc_data,
    input  logic                  sb_set,
    input  logic [REG_ADDR_W-1:0] sb_addr,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    output logic                  rs_busy,
    output logic                  rt_busy,
    output logic                  stall_req,
    output logic                  rf_wr,
    output logic [REG_ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0]     rf_data
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_chk
        $error("rf_wb_arbiter: STARVE_LIMIT must be in 1..15");
    end

    arb_state_e            state_q, state_d;
    logic [REG_ADDR_W-1:0] held_addr_q;
    logic [DATA_W-1:0]     held_data_q;
    logic                  pipe_live;
    logic                  held_valid;
    logic                  grant;
    logic                  load;

    assign pipe_live  = wb_wr & is_gpr(wb_addr);
    assign held_valid = (state_q != IDLE);
    assign grant      = held_valid & ~pipe_live;
    assign mc_ready   = ~held_valid;
    assign load       = mc_valid & mc_ready & is_gpr(mc_addr);

    // Combinational so the register file can sample on the falling edge.
    always_comb begin
        rf_wr   = 1'b0;
        rf_addr = REG_ZERO;
        rf_data = '0;
        if (pipe_live) begin
            rf_wr   = 1'b1;
            rf_addr = wb_addr;
            rf_data = wb_data;
        end else if (held_valid) begin
            rf_wr   = 1'b1;
            rf_addr = held_addr_q;
            rf_data = held_data_q;
        end
    end

`ifdef RF_WB_STARVE_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end
            end
            HELD: begin
                if (grant) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d >= LIMIT) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                if (grant) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_req = (state_q == FORCE);
`else
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load)  state_d = HELD;
            HELD:    if (grant) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign stall_req = 1'b0;
`endif

    // Payload is only meaningful while the state says the hold is valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            held_addr_q <= mc_addr;
            held_data_q <= mc_data;
        end
    end

    rf_scoreboard u_sb (
        .clk        (clk),
        .reset      (reset),
        .set_i      (sb_set),
        .set_addr_i (sb_addr),
        .clr_i      (grant),
        .clr_addr_i (held_addr_q),
        .rs_addr_i  (rs_addr),
        .rt_addr_i  (rt_addr),
        .rs_busy_o  (rs_busy),
        .rt_busy_o  (rt_busy)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: expected port writes are queued per cycle and popped at negedge.
module tb_rf_wb_arbiter;

    localparam int DATA_W = 32;

`ifdef RF_WB_STARVE_EN
    localparam logic STARVE_ON = 1'b1;
`else
    localparam logic STARVE_ON = 1'b0;
`endif

    typedef struct {
        logic [4:0]        addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              wb_wr;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              mc_valid;
    logic              mc_ready;
    logic [4:0]        mc_addr;
    logic [DATA_W-1:0] mc_data;
    logic              sb_set;
    logic [4:0]        sb_addr;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic              rs_busy;
    logic              rt_busy;
    logic              stall_req;
    logic              rf_wr;
    logic [4:0]        rf_addr;
    logic [DATA_W-1:0] rf_data;

    int  total = 0;
    int  bad   = 0;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    rf_wb_arbiter #(.STARVE_LIMIT(4), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_wr     (wb_wr),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .mc_valid  (mc_valid),
        .mc_ready  (mc_ready),
        .mc_addr   (mc_addr),
        .mc_data   (mc_data),
        .sb_set    (sb_set),
        .sb_addr   (sb_addr),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_busy   (rs_busy),
        .rt_busy   (rt_busy),
        .stall_req (stall_req),
        .rf_wr     (rf_wr),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [4:0] a, input logic [DATA_W-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Every cycle: a write must appear exactly when one is expected, with the expected payload.
    always @(negedge clk) begin
        wr_t e;
        chk("wr_present", {31'd0, rf_wr}, {31'd0, exp_q.size() != 0});
        if (rf_wr && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", {27'd0, rf_addr}, {27'd0, e.addr});
            chk("wr_data", rf_data, e.data);
        end
    end

    initial begin
        reset    = 1'b0;
        wb_wr    = 1'b0; wb_addr = '0; wb_data = '0;
        mc_valid = 1'b0; mc_addr = '0; mc_data = '0;
        sb_set   = 1'b0; sb_addr = '0;
        rs_addr  = 5'd8; rt_addr = 5'd9;

        #3;
        chk("rst_mc_ready", {31'd0, mc_ready}, 32'd1);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_rf_wr", {31'd0, rf_wr}, 32'd0);
        chk("rst_rs_busy", {31'd0, rs_busy}, 32'd0);
        next_cyc();
        next_cyc();
        reset = 1'b1;

        // Basic accept then write one cycle later
        sb_set = 1'b1; sb_addr = 5'd8;
        next_cyc();
        sb_set = 1'b0;
        mc_valid = 1'b1; mc_addr = 5'd8; mc_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("a_busy_set", {31'd0, rs_busy}, 32'd1);
        chk("a_ready_idle", {31'd0, mc_ready}, 32'd1);
        next_cyc();
        mc_valid = 1'b0;
        push_exp(5'd8, 32'hDEADBEEF);
        @(negedge clk);
        chk("a_ready_held", {31'd0, mc_ready}, 32'd0);
        chk("a_stall", {31'd0, stall_req}, 32'd0);
        next_cyc();
        @(negedge clk);
        chk("a_ready_after", {31'd0, mc_ready}, 32'd1);
        chk("a_busy_clr", {31'd0, rs_busy}, 32'd0);

        // Async reset while holding r8 with busy[8] set
        next_cyc();
        sb_set = 1'b1; sb_addr = 5'd8;
        next_cyc();
        sb_set = 1'b0;
        mc_valid = 1'b1; mc_addr = 5'd8; mc_data = 32'h0000_0088;
        wb_wr = 1'b1; wb_addr = 5'd4; wb_data = 32'h0000_0044;
        push_exp(5'd4, 32'h0000_0044);
        next_cyc();
        mc_valid = 1'b0;
        push_exp(5'd4, 32'h0000_0044);
        @(negedge clk);
        chk("g_ready_held", {31'd0, mc_ready}, 32'd0);
        chk("g_busy_pre", {31'd0, rs_busy}, 32'd1);
        next_cyc();
        wb_wr = 1'b0;
        reset = 1'b0;
        #1;
        chk("g_rf_wr", {31'd0, rf_wr}, 32'd0);
        chk("g_mc_ready", {31'd0, mc_ready}, 32'd1);
        chk("g_busy8", {31'd0, rs_busy}, 32'd0);
        chk("g_stall", {31'd0, stall_req}, 32'd0);
        next_cyc();
        reset = 1'b1;
        next_cyc();
        @(negedge clk);
        chk("g_ready_post", {31'd0, mc_ready}, 32'd1);

        // Starvation of r9 behind four pipeline writes to r3
        next_cyc();
        sb_set = 1'b1; sb_addr = 5'd9;
        mc_valid = 1'b1; mc_addr = 5'd9; mc_data = 32'h0000_0099;
        next_cyc();
        sb_set = 1'b0; mc_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wb_wr = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_0300 + i;
            push_exp(5'd3, 32'h0000_0300 + i);
            @(negedge clk);
            chk("b_stall_lose", {31'd0, stall_req}, 32'd0);
            chk("b_ready_lose", {31'd0, mc_ready}, 32'd0);
            chk("b_busy9", {31'd0, rt_busy}, 32'd1);
            next_cyc();
        end
        wb_wr = 1'b0;
        push_exp(5'd9, 32'h0000_0099);
        @(negedge clk);
        chk("b_stall_force", {31'd0, stall_req}, {31'd0, STARVE_ON});
        next_cyc();
        @(negedge clk);
        chk("b_stall_drop", {31'd0, stall_req}, 32'd0);
        chk("b_ready_after", {31'd0, mc_ready}, 32'd1);
        chk("b_busy9_clr", {31'd0, rt_busy}, 32'd0);

        // wb_wr to r0 is a free slot
        next_cyc();
        mc_valid = 1'b1; mc_addr = 5'd9; mc_data = 32'h1234_5678;
        next_cyc();
        mc_valid = 1'b0;
        wb_wr = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_0BAD;
        push_exp(5'd9, 32'h1234_5678);
        @(negedge clk);
        chk("c_ready_held", {31'd0, mc_ready}, 32'd0);
        next_cyc();
        wb_wr = 1'b0;
        @(negedge clk);
        chk("c_ready_after", {31'd0, mc_ready}, 32'd1);

        // Set and grant-clear of r12 in the same cycle: set wins
        next_cyc();
        rs_addr = 5'd12;
        sb_set = 1'b1; sb_addr = 5'd12;
        mc_valid = 1'b1; mc_addr = 5'd12; mc_data = 32'h0000_C0C0;
        next_cyc();
        mc_valid = 1'b0;
        push_exp(5'd12, 32'h0000_C0C0);
        @(negedge clk);
        chk("d_busy_pre", {31'd0, rs_busy}, 32'd1);
        next_cyc();
        sb_set = 1'b0;
        @(negedge clk);
        chk("d_set_wins", {31'd0, rs_busy}, 32'd1);
        next_cyc();
        mc_valid = 1'b1; mc_addr = 5'd12; mc_data = 32'h0000_00C1;
        next_cyc();
        mc_valid = 1'b0;
        push_exp(5'd12, 32'h0000_00C1);
        next_cyc();
        @(negedge clk);
        chk("d_busy_clr", {31'd0, rs_busy}, 32'd0);

        // Accept to r0 is dropped
        next_cyc();
        mc_valid = 1'b1; mc_addr = 5'd0; mc_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("e_ready_offer", {31'd0, mc_ready}, 32'd1);
        next_cyc();
        mc_valid = 1'b0;
        @(negedge clk);
        chk("e_ready_after", {31'd0, mc_ready}, 32'd1);
        chk("e_no_write", {31'd0, rf_wr}, 32'd0);

        // WAW: pipeline write to a busy register goes through, busy bit stays
        next_cyc();
        sb_set = 1'b1; sb_addr = 5'd5;
        next_cyc();
        sb_set = 1'b0;
        rs_addr = 5'd5;
        wb_wr = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_0055;
        push_exp(5'd5, 32'h0000_0055);
        next_cyc();
        wb_wr = 1'b0;
        @(negedge clk);
        chk("f_busy_kept", {31'd0, rs_busy}, 32'd1);

        next_cyc();
        next_cyc();
        chk("q_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
